// File: rtl/fifo_pop_arbiter.sv
// Round-robin pop arbiter for a bank of source FIFOs feeding one downstream FIFO.
// Pop decisions are combinational; the popped word is pushed downstream one cycle later.
module fifo_pop_arbiter #(
    parameter int DATA_WIDTH = 6,
    parameter int NUM_FIFOS  = 4
) (
    input  logic                            clk,
    input  logic                            reset_L,
    input  logic [NUM_FIFOS-1:0]            Fifo_Empty,
    input  logic [NUM_FIFOS*DATA_WIDTH-1:0] Fifo_Data_out,
    input  logic [NUM_FIFOS-1:0]            Error_Fifo,
    input  logic                            Pausa,
    input  logic                            Error_down,
    output logic [NUM_FIFOS-1:0]            pop,
    output logic                            push,
    output logic [DATA_WIDTH-1:0]           Data_out,
    output logic                            active,
    output logic                            idle,
    output logic                            Error_out,
    output logic [1:0]                      state
);

    localparam int PW = (NUM_FIFOS > 1) ? $clog2(NUM_FIFOS) : 1;

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_IDLE   = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_PAUSED = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [PW-1:0]         ptr_q, ptr_d;
    logic [NUM_FIFOS-1:0]  last_pop_q, last_pop_d;
    logic [PW-1:0]         sel_q, sel_d;
    logic                  valid_q, valid_d;
    logic                  gnt_empty_q, gnt_empty_d;
    logic                  err_q, err_d;

    logic [NUM_FIFOS-1:0]  elig_s;
    logic [NUM_FIFOS-1:0]  grant_s;
    logic                  gnt_found_s;
    logic [PW-1:0]         gnt_idx_s;
    logic [PW-1:0]         idx_v;
    logic                  any_ne_s;
    logic                  any_elig_s;
    logic                  can_grant_s;

    // Eligibility masks out the source popped last cycle, since its empty flag lags by one cycle.
    always_comb begin
        elig_s      = ~Fifo_Empty & ~last_pop_q;
        any_ne_s    = ~(&Fifo_Empty);
        any_elig_s  = |elig_s;
        can_grant_s = ~Pausa & (state_q != ST_INIT);
    end

    // Round-robin search starting just after the last granted source.
    always_comb begin
        grant_s     = '0;
        gnt_found_s = 1'b0;
        gnt_idx_s   = ptr_q;
        idx_v       = '0;
        if (can_grant_s) begin
            for (int k = 1; k <= NUM_FIFOS; k++) begin
                idx_v = PW'((int'(ptr_q) + k) % NUM_FIFOS);
                if (!gnt_found_s && elig_s[idx_v]) begin
                    gnt_found_s = 1'b1;
                    gnt_idx_s   = idx_v;
                end else begin
                    gnt_found_s = gnt_found_s;
                end
            end
        end else begin
            gnt_found_s = 1'b0;
        end
        if (gnt_found_s) begin
            grant_s[gnt_idx_s] = 1'b1;
        end else begin
            grant_s = '0;
        end
    end

    // Next-state logic of the controller.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT: state_d = ST_IDLE;
            ST_IDLE: begin
                if (any_elig_s && !Pausa) begin
                    state_d = ST_ACTIVE;
                end else if (any_ne_s && Pausa) begin
                    state_d = ST_PAUSED;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (Pausa) begin
                    state_d = ST_PAUSED;
                end else if (!any_elig_s && !any_ne_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_ACTIVE;
                end
            end
            ST_PAUSED: begin
                if (!Pausa && any_ne_s) begin
                    state_d = ST_ACTIVE;
                end else if (!Pausa) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_PAUSED;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    // Pointer, in-flight capture and sticky error next values.
    always_comb begin
        last_pop_d = grant_s;
        valid_d    = gnt_found_s;
        if (gnt_found_s) begin
            ptr_d       = gnt_idx_s;
            sel_d       = gnt_idx_s;
            gnt_empty_d = Fifo_Empty[gnt_idx_s];
        end else begin
            ptr_d       = ptr_q;
            sel_d       = sel_q;
            gnt_empty_d = 1'b0;
        end
        err_d = err_q | (|Error_Fifo) | Error_down | (valid_q & gnt_empty_q);
    end

    // State registers; reset drops any in-flight word.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q     <= ST_INIT;
            ptr_q       <= PW'(NUM_FIFOS - 1);
            last_pop_q  <= '0;
            sel_q       <= '0;
            valid_q     <= 1'b0;
            gnt_empty_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            last_pop_q  <= last_pop_d;
            sel_q       <= sel_d;
            valid_q     <= valid_d;
            gnt_empty_q <= gnt_empty_d;
            err_q       <= err_d;
        end
    end

    // Source memory presents the popped word one cycle after the pop.
    always_comb begin
        if (valid_q) begin
            Data_out = Fifo_Data_out[sel_q*DATA_WIDTH +: DATA_WIDTH];
        end else begin
            Data_out = '0;
        end
    end

    assign pop       = grant_s;
    assign push      = valid_q;
    assign active    = (state_q == ST_ACTIVE);
    assign idle      = (state_q == ST_INIT) || (state_q == ST_IDLE);
    assign Error_out = err_q;
    assign state     = state_q;

endmodule

// File: tb/tb_fifo_pop_arbiter.sv
// Randomized bench for fifo_pop_arbiter against a queue-based model of sources and arbitration rules.
module tb_fifo_pop_arbiter;
    localparam int DW = 6;
    localparam int NF = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset_L;
    logic [NF-1:0]     Fifo_Empty;
    logic [NF*DW-1:0]  Fifo_Data_out;
    logic [NF-1:0]     Error_Fifo;
    logic              Pausa;
    logic              Error_down;
    logic [NF-1:0]     pop;
    logic              push;
    logic [DW-1:0]     Data_out;
    logic              active;
    logic              idle;
    logic              Error_out;
    logic [1:0]        state;

    fifo_pop_arbiter #(.DATA_WIDTH(DW), .NUM_FIFOS(NF)) dut (
        .clk(clk), .reset_L(reset_L), .Fifo_Empty(Fifo_Empty), .Fifo_Data_out(Fifo_Data_out),
        .Error_Fifo(Error_Fifo), .Pausa(Pausa), .Error_down(Error_down), .pop(pop), .push(push),
        .Data_out(Data_out), .active(active), .idle(idle), .Error_out(Error_out), .state(state)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Source FIFO contents (words still held by each source)
    logic [DW-1:0] srcq [NF][$];

    // Arbiter reference model: 0=INIT 1=IDLE 2=ACTIVE 3=PAUSED
    int            m_state, m_ptr, m_last, m_valid;
    logic [DW-1:0] m_word;
    bit            m_err;
    int            gnt_log[$];
    int            push_log[$];

    task automatic model_reset();
        m_state = 0; m_ptr = 3; m_last = -1; m_valid = 0; m_word = '0; m_err = 1'b0;
    endtask

    task automatic load(input int src, input logic [DW-1:0] w);
        srcq[src].push_back(w);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_pop"}, pop, 0);
        check_val({tag, "_push"}, push, 0);
        check_val({tag, "_data"}, Data_out, 0);
        check_val({tag, "_state"}, state, 0);
        check_val({tag, "_active"}, active, 0);
        check_val({tag, "_idle"}, idle, 1);
        check_val({tag, "_err"}, Error_out, 0);
    endtask

    // One clock cycle: drive inputs, check outputs against the model, then advance model and sources.
    task automatic cycle(input bit pausa, input logic [NF-1:0] efifo, input bit edown);
        int g, ns;
        bit any_ne, any_el;
        logic [NF-1:0] pop_seen;
        logic [DW-1:0] nword;
        Pausa = pausa; Error_Fifo = efifo; Error_down = edown;
        #3;
        g = -1;
        any_el = 1'b0;
        for (int k = 1; k <= NF; k++) begin
            int i;
            i = (m_ptr + k) % NF;
            if (!Fifo_Empty[i] && i != m_last) begin
                any_el = 1'b1;
                if (g < 0 && !pausa && m_state != 0) g = i;
            end
        end
        any_ne = (Fifo_Empty != 4'hF);
        check_val("pop", pop, (g >= 0) ? (32'd1 << g) : 32'd0);
        check_val("push", push, m_valid);
        if (m_valid != 0) begin
            check_val("data", Data_out, m_word);
            push_log.push_back(int'(Data_out));
        end
        check_val("state", state, m_state);
        check_val("active", active, (m_state == 2) ? 1 : 0);
        check_val("idle", idle, (m_state < 2) ? 1 : 0);
        check_val("error", Error_out, m_err);
        if (g >= 0) gnt_log.push_back(g);
        case (m_state)
            0: ns = 1;
            1: ns = (any_el && !pausa) ? 2 : ((any_ne && pausa) ? 3 : 1);
            2: ns = pausa ? 3 : ((!any_el && !any_ne) ? 1 : 2);
            default: ns = pausa ? 3 : (any_ne ? 2 : 1);
        endcase
        nword = (g >= 0 && srcq[g].size() > 0) ? srcq[g][0] : '0;
        pop_seen = pop;
        @(posedge clk);
        #1;
        m_err   = m_err | (|efifo) | edown;
        m_state = ns;
        if (g >= 0) m_ptr = g;
        m_last  = g;
        m_valid = (g >= 0) ? 1 : 0;
        m_word  = nword;
        // Sources: read data registered on pop, empty flag lags one cycle
        for (int i = 0; i < NF; i++) begin
            bit was_empty;
            was_empty = (srcq[i].size() == 0);
            if (pop_seen[i] && !was_empty) Fifo_Data_out[i*DW +: DW] = srcq[i].pop_front();
            Fifo_Empty[i] = was_empty;
        end
    endtask

    task automatic do_reset();
        reset_L = 1'b0;
        #1;
        check_reset_outputs("rst_async");
        @(posedge clk);
        #1;
        reset_L = 1'b1;
        model_reset();
    endtask

    initial begin
        reset_L = 1'b0; Fifo_Empty = 4'hF; Fifo_Data_out = '0;
        Error_Fifo = '0; Pausa = 1'b0; Error_down = 1'b0;
        model_reset();
        #12;
        check_reset_outputs("rst_init");
        @(posedge clk);
        #1;
        reset_L = 1'b1;

        // Idle after reset with everything empty
        repeat (3) cycle(1'b0, 4'h0, 1'b0);

        // Four sources, two words each: strict round robin
        for (int i = 0; i < NF; i++) begin
            load(i, DW'(2*i + 1));
            load(i, DW'(2*i + 2));
        end
        gnt_log.delete(); push_log.delete();
        repeat (14) cycle(1'b0, 4'h0, 1'b0);
        check_val("rr_count", gnt_log.size(), 8);
        check_val("push_count", push_log.size(), 8);
        for (int j = 0; j < 8; j++) begin
            int exp_src, exp_word;
            exp_src = j % 4;
            exp_word = (j < 4) ? (2*j + 1) : (2*(j-4) + 2);
            if (j < gnt_log.size()) check_val("rr_order", gnt_log[j], exp_src);
            if (j < push_log.size()) check_val("push_order", push_log[j], exp_word);
        end

        // Single source: pops every other cycle
        load(2, 6'h11); load(2, 6'h12); load(2, 6'h13);
        gnt_log.delete();
        repeat (10) cycle(1'b0, 4'h0, 1'b0);
        check_val("single_count", gnt_log.size(), 3);
        check_val("single_idle", state, 1);

        // Pausa in the middle of a stream
        for (int i = 0; i < NF; i++) begin
            load(i, DW'($urandom)); load(i, DW'($urandom));
        end
        cycle(1'b1, 4'h0, 1'b0);
        repeat (2) cycle(1'b0, 4'h0, 1'b0);
        repeat (3) cycle(1'b1, 4'h0, 1'b0);
        repeat (14) cycle(1'b0, 4'h0, 1'b0);

        // Reset between a pop and its push
        load(0, 6'h2A);
        repeat (2) cycle(1'b0, 4'h0, 1'b0);
        check_val("inflight_push", push, 1);
        do_reset();
        repeat (3) cycle(1'b0, 4'h0, 1'b0);

        // Error pulse: sticky, arbitration continues
        for (int i = 0; i < NF; i++) load(i, DW'($urandom));
        cycle(1'b0, 4'b1000, 1'b0);
        repeat (8) cycle(1'b0, 4'h0, 1'b0);

        // Randomized traffic and flow control
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NF; i++)
                if (srcq[i].size() < 4 && $urandom_range(0, 99) < 30) load(i, DW'($urandom));
            cycle(($urandom_range(0, 99) < 30) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 999) < 3) ? 4'(1 << $urandom_range(0, 3)) : 4'h0,
                  ($urandom_range(0, 999) < 2) ? 1'b1 : 1'b0);
        end
        // Alternating Pausa with all sources busy
        for (int i = 0; i < NF; i++) begin
            load(i, DW'($urandom)); load(i, DW'($urandom)); load(i, DW'($urandom));
        end
        for (int c = 0; c < 30; c++) cycle(c[0], 4'h0, 1'b0);
        do_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/fifo_pop_arbiter.md
Name: fifo_pop_arbiter

Overview:
- Read-side controller for a bank of four 6-bit source FIFOs.
- Decides which FIFO to pop, captures the word that FIFO presents one cycle later, and pushes it into a single downstream FIFO.
- Honours the downstream Pausa (almost-full) flow control.
- Sits between the per-class input FIFOs and the shared output FIFO.

Parameters:
- DATA_WIDTH, 6, width of each FIFO word.
- NUM_FIFOS, 4, number of source FIFOs; the design is verified at 4 only.

Ports:
- clk  input  1  single clock, all logic on posedge.
- reset_L  input  1  asynchronous, active-low reset.
- Fifo_Empty  input  NUM_FIFOS  per-source empty flag; bit i belongs to source i.
- Fifo_Data_out  input  NUM_FIFOS*DATA_WIDTH  source read data; source i occupies bits [i*6+5 : i*6].
- Error_Fifo  input  NUM_FIFOS  per-source error flags.
- Pausa  input  1  downstream FIFO almost-full.
- Error_down  input  1  downstream FIFO error.
- pop  output  NUM_FIFOS  one-hot (or zero) pop request to the sources.
- push  output  1  push to the downstream FIFO.
- Data_out  output  DATA_WIDTH  word to the downstream FIFO.
- active  output  1  high in ACTIVE state.
- idle  output  1  high in INIT and IDLE states.
- Error_out  output  1  sticky error.
- state  output  2  encoded state: INIT=0, IDLE=1, ACTIVE=2, PAUSED=3.

Behaviour:
- Reset (asynchronous, any time, including mid-transfer):
  - pop=0, push=0, Data_out=0, state=INIT, active=0, idle=1, Error_out=0.
  - RR pointer=3, so source 0 has first priority.
  - last-pop register=0; an in-flight word is dropped.
- State machine, evaluated each posedge:
  - INIT -> IDLE unconditionally, one cycle after reset release. No pops in INIT.
  - IDLE: if any eligible source exists and Pausa=0 -> ACTIVE; if any source is non-empty and Pausa=1 -> PAUSED; else stay.
  - ACTIVE: Pausa=1 -> PAUSED; no eligible and all empty -> IDLE; else stay.
  - PAUSED: Pausa=0 and any non-empty -> ACTIVE; Pausa=0 and all empty -> IDLE.
- Eligibility: source i is eligible when Fifo_Empty[i]=0 and source i was not popped in the previous cycle. This covers the one-cycle lag of the source empty flag, so any single source is popped at most every other cycle.
- Grant (combinational from registered state plus inputs):
  - Issued only when Pausa=0 and state is IDLE, ACTIVE or PAUSED.
  - Selects the first eligible source searching from (RR pointer+1) mod 4 upward with wrap.
  - pop = one-hot of the selected source; the RR pointer and last-pop register update on the posedge that ends the grant cycle.
  - No grant -> pop=0 and the pointer holds.
- Datapath, latency 1:
  - A pop in cycle T registers sel=i and valid=1.
  - In cycle T+1, push=1 and Data_out = source i's slice of Fifo_Data_out; the source memory presents its data the cycle after pop.
  - Sustained throughput is 1 word/cycle when at least 2 sources are non-empty, and 1 word per 2 cycles with a single non-empty source.
- Pausa boundary: Pausa=1 in cycle T blocks a new pop in T, but a word popped in T-1 is still pushed in T; the downstream almost-full slack absorbs it. Pausa never cancels an in-flight push.
- Simultaneous events: all sources non-empty with Pausa toggling each cycle -> pops occur only in Pausa=0 cycles, in strict RR order with no source skipped.
- Error_out:
  - Set on a posedge where any Error_Fifo bit or Error_down is 1, or where push=1 while a source reported Fifo_Empty=1 at its grant cycle (protocol check).
  - Sticky; cleared only by reset. It does not stop arbitration.

Test Plan:
- Reset release with all Fifo_Empty=4'b1111 -> state INIT for 1 cycle, then IDLE; pop=0, push=0, idle=1 throughout.
- All four sources hold 2 words (values 0x01..0x08, source i gives 2i+1 then 2i+2), Pausa=0 -> pop order 0,1,2,3,0,1,2,3 on consecutive cycles; push sequence 0x01,0x03,0x05,0x07,0x02,0x04,0x06,0x08, each one cycle after its pop.
- Only source 2 non-empty with 3 words -> pop=4'b0100 on alternate cycles only; 3 pushes over 6 cycles; then IDLE.
- Pausa rises in the cycle after a pop of source 1 -> that word is still pushed; pop=0 while Pausa=1; state=PAUSED; on Pausa fall, the next grant is source 2.
- Reset asserted asynchronously between a pop and its push -> push never asserts; all outputs return to reset values immediately, without waiting for a clock edge.
- Error_Fifo[3] pulsed for 1 cycle -> Error_out=1 from the next posedge and remains 1 until reset; pops continue normally.
